// File: rtl/melody_pkg.sv
// Shared definitions for the melody sequencer: field widths, note and state
// encodings, the tone half-period table and the song ROM contents.
package melody_pkg;

  localparam int NOTE_W   = 3;
  localparam int DUR_W    = 4;
  localparam int STEP_W   = 4;
  localparam int HALF_W   = 16;
  localparam int SAMPLE_W = 24;

  typedef enum logic [NOTE_W-1:0] {
    NOTE_REST = 3'd0,
    NOTE_C    = 3'd1,
    NOTE_D    = 3'd2,
    NOTE_E    = 3'd3,
    NOTE_F    = 3'd4,
    NOTE_G    = 3'd5,
    NOTE_A    = 3'd6,
    NOTE_B    = 3'd7
  } note_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_PLAY = 3'd2,
    ST_GAP  = 3'd3,
    ST_NEXT = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  // One ROM word: note in the upper bits, duration in beat ticks below.
  // A zero duration marks the end of the song.
  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  dur;
  } rom_entry_t;

  // Half period of each note in 50 MHz clocks; a rest has no tone.
  function automatic logic [HALF_W-1:0] note_half_period(input logic [NOTE_W-1:0] note);
    logic [HALF_W-1:0] half;
    case (note)
      NOTE_C:  half = 16'd47778;
      NOTE_D:  half = 16'd42566;
      NOTE_E:  half = 16'd37922;
      NOTE_F:  half = 16'd35793;
      NOTE_G:  half = 16'd31888;
      NOTE_A:  half = 16'd28409;
      NOTE_B:  half = 16'd25310;
      default: half = 16'd0;
    endcase
    return half;
  endfunction

  // Square-wave level for a note: silent for a rest, otherwise +/- amplitude.
  function automatic logic [SAMPLE_W-1:0] square_level(input logic [NOTE_W-1:0]   note,
                                                       input logic                  phase,
                                                       input logic [SAMPLE_W-1:0] ampl);
    logic [SAMPLE_W-1:0] level;
    if (note == NOTE_REST) level = '0;
    else if (phase)        level = ampl;
    else                   level = -ampl;
    return level;
  endfunction

  function automatic rom_entry_t make_entry(input note_e note, input logic [DUR_W-1:0] dur);
    rom_entry_t entry;
    entry.note = note;
    entry.dur  = dur;
    return entry;
  endfunction

  // Song ROM: sel 0 is the demo tune (runs the full 16 steps), sel 1 is a
  // short tune with an early end marker.
  function automatic rom_entry_t song_rom(input int unsigned sel, input logic [STEP_W-1:0] idx);
    rom_entry_t entry;
    entry = make_entry(NOTE_REST, 4'd0);
    if (sel == 1) begin
      case (idx)
        4'd0:    entry = make_entry(NOTE_C, 4'd2);
        4'd1:    entry = make_entry(NOTE_REST, 4'd1);
        4'd2:    entry = make_entry(NOTE_E, 4'd1);
        default: entry = make_entry(NOTE_REST, 4'd0);
      endcase
    end else begin
      case (idx)
        4'd0:    entry = make_entry(NOTE_E, 4'd2);
        4'd1:    entry = make_entry(NOTE_E, 4'd2);
        4'd2:    entry = make_entry(NOTE_F, 4'd2);
        4'd3:    entry = make_entry(NOTE_G, 4'd2);
        4'd4:    entry = make_entry(NOTE_G, 4'd2);
        4'd5:    entry = make_entry(NOTE_F, 4'd2);
        4'd6:    entry = make_entry(NOTE_E, 4'd2);
        4'd7:    entry = make_entry(NOTE_D, 4'd2);
        4'd8:    entry = make_entry(NOTE_C, 4'd2);
        4'd9:    entry = make_entry(NOTE_C, 4'd2);
        4'd10:   entry = make_entry(NOTE_D, 4'd2);
        4'd11:   entry = make_entry(NOTE_E, 4'd2);
        4'd12:   entry = make_entry(NOTE_E, 4'd3);
        4'd13:   entry = make_entry(NOTE_D, 4'd1);
        4'd14:   entry = make_entry(NOTE_D, 4'd4);
        default: entry = make_entry(NOTE_REST, 4'd2);
      endcase
    end
    return entry;
  endfunction

endpackage

// File: rtl/melody_sequencer_if.sv
// Sample write port between the melody sequencer and the audio codec.
interface melody_sequencer_if;
  import melody_pkg::*;

  logic                write;
  logic                write_ready;
  logic [SAMPLE_W-1:0] sample_left;
  logic [SAMPLE_W-1:0] sample_right;

  modport master (output write, output sample_left, output sample_right, input write_ready);
  modport slave  (input write, input sample_left, input sample_right, output write_ready);

endinterface

// File: rtl/melody_sequencer_tone_gen.sv
// Square-wave phase generator: toggles the phase every half_period clocks.
module tone_gen
  import melody_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              clr,
  input  logic [HALF_W-1:0] half_period,
  output logic              phase
);

  logic [HALF_W-1:0] cnt_q, cnt_d;
  logic              phase_q, phase_d;

  // Restart on clr, stay still on a zero period, toggle phase at terminal count
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (clr) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (half_period == '0) begin
      cnt_d = '0;
    end else if (cnt_q >= half_period - 1'b1) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Tone counter and phase registers, cleared by the synchronous reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/melody_sequencer.sv
// Melody sequencer: walks the song ROM, times each note in beat ticks and
// streams square-wave samples to the codec through a write/write_ready port.
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int unsigned         BEAT_DIV       = 6_250_000,
  parameter int unsigned         GAP_TICKS      = 1,
  parameter int unsigned         SONG_LEN       = 16,
  parameter int unsigned         SONG_SEL       = 0,
  parameter int unsigned         TONE_DIV_SHIFT = 0,
  parameter logic [SAMPLE_W-1:0] AMPL           = 24'h200000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               loop_en,
  melody_sequencer_if.master codec,
  output logic [NOTE_W-1:0]  note_id,
  output logic [STEP_W-1:0]  step_idx,
  output logic               busy,
  output logic               done
);

  localparam int PRESC_W = $clog2(BEAT_DIV);
  localparam int CNT_W   = (GAP_TICKS > 15) ? $clog2(GAP_TICKS + 1) : DUR_W;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(BEAT_DIV - 1);
  localparam logic [CNT_W-1:0]   GAP_LAST   = (GAP_TICKS > 0) ? CNT_W'(GAP_TICKS - 1) : '0;
  localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(SONG_LEN - 1);

  state_e              state_q,   state_d;
  logic [STEP_W-1:0]   step_q,    step_d;
  logic [NOTE_W-1:0]   note_q,    note_d;
  logic [DUR_W-1:0]    dur_q,     dur_d;
  logic [CNT_W-1:0]    dur_cnt_q, dur_cnt_d;
  logic [PRESC_W-1:0]  presc_q,   presc_d;
  logic                write_q,   write_d;
  logic [SAMPLE_W-1:0] sample_q,  sample_d;
  logic                busy_q,    busy_d;
  logic                done_q,    done_d;

  rom_entry_t          entry;
  logic                timing;
  logic                beat_tick;
  logic                tone_clr;
  logic                tone_phase;
  logic [HALF_W-1:0]   tone_half;

  assign entry     = song_rom(SONG_SEL, step_q);
  assign timing    = (state_q == ST_PLAY) || (state_q == ST_GAP);
  assign beat_tick = timing && (presc_q == PRESC_LAST);
  assign tone_clr  = (state_q != ST_PLAY);
  assign tone_half = note_half_period(note_q) >> TONE_DIV_SHIFT;

  tone_gen u_tone_gen (
    .clock       (clock),
    .reset       (reset),
    .clr         (tone_clr),
    .half_period (tone_half),
    .phase       (tone_phase)
  );

  // Next-state logic for the sequencer, its counters and its registered outputs
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    note_d    = note_q;
    dur_d     = dur_q;
    dur_cnt_d = dur_cnt_q;
    presc_d   = '0;
    sample_d  = sample_q;

    if (timing) begin
      presc_d = beat_tick ? '0 : presc_q + 1'b1;
    end

    if (write_q && codec.write_ready) begin
      sample_d = square_level(note_q, tone_phase, AMPL);
    end

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        note_d    = entry.note;
        dur_d     = entry.dur;
        dur_cnt_d = '0;
        if (entry.dur == '0) begin
          state_d = ST_DONE;
        end else begin
          state_d  = ST_PLAY;
          sample_d = square_level(entry.note, 1'b0, AMPL);
        end
      end
      ST_PLAY: begin
        if (beat_tick) begin
          if (dur_cnt_q == CNT_W'(dur_q - 1'b1)) begin
            dur_cnt_d = '0;
            if (GAP_TICKS > 0) begin
              state_d = ST_GAP;
              note_d  = NOTE_REST;
            end else begin
              state_d = ST_NEXT;
            end
          end else begin
            dur_cnt_d = dur_cnt_q + 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (beat_tick) begin
          if (dur_cnt_q == GAP_LAST) begin
            dur_cnt_d = '0;
            state_d   = ST_NEXT;
          end else begin
            dur_cnt_d = dur_cnt_q + 1'b1;
          end
        end
      end
      ST_NEXT: begin
        if (step_q == STEP_LAST) begin
          state_d = ST_DONE;
        end else begin
          step_d  = step_q + 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_DONE: begin
        step_d  = '0;
        state_d = loop_en ? ST_LOAD : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (stop) begin
      state_d   = ST_IDLE;
      step_d    = '0;
      dur_cnt_d = '0;
      presc_d   = '0;
    end

    if ((state_d == ST_IDLE) || (state_d == ST_DONE)) begin
      note_d = NOTE_REST;
    end

    write_d = (state_d == ST_PLAY) || (state_d == ST_GAP);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);

    if (!write_d) begin
      sample_d = '0;
    end
  end

  // Sequencer registers, cleared by the synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      step_q    <= '0;
      note_q    <= '0;
      dur_q     <= '0;
      dur_cnt_q <= '0;
      presc_q   <= '0;
      write_q   <= 1'b0;
      sample_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      note_q    <= note_d;
      dur_q     <= dur_d;
      dur_cnt_q <= dur_cnt_d;
      presc_q   <= presc_d;
      write_q   <= write_d;
      sample_q  <= sample_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign codec.write        = write_q;
  assign codec.sample_left  = sample_q;
  assign codec.sample_right = sample_q;
  assign note_id            = note_q;
  assign step_idx           = step_q;
  assign busy               = busy_q;
  assign done               = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer running the short bench tune
// {C,2},{rest,1},{E,1},{end} with a fast prescaler and scaled-down tones.
// With BEAT = 8 a one-beat note lasts 8 clocks, long enough to see the C tone
// (half period 47778>>12 = 11 clocks) change phase within the note.
module tb_melody_sequencer;
  import melody_pkg::*;

  localparam int BEAT = 8;

  localparam logic [23:0] POS = 24'h200000;
  localparam logic [23:0] NEG = 24'hE00000;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       stop;
  logic       loop_en;
  logic [2:0] note_id;
  logic [3:0] step_idx;
  logic       busy;
  logic       done;

  int check_count = 0;
  int fail_count  = 0;
  int cycles;

  melody_sequencer_if codec_bus ();

  melody_sequencer #(
    .BEAT_DIV       (BEAT),
    .GAP_TICKS      (1),
    .SONG_LEN       (16),
    .SONG_SEL       (1),
    .TONE_DIV_SHIFT (12),
    .AMPL           (POS)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .loop_en  (loop_en),
    .codec    (codec_bus),
    .note_id  (note_id),
    .step_idx (step_idx),
    .busy     (busy),
    .done     (done)
  );

  always #5 clock = ~clock;

  task automatic applyStimulus(input logic rst, input logic st, input logic sp,
                               input logic lp, input logic wr);
    reset                 = rst;
    start                 = st;
    stop                  = sp;
    loop_en               = lp;
    codec_bus.write_ready = wr;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Checks every registered output once per cycle over a span of equal cycles
  task automatic checkSpan(input string tag, input int n, input logic [2:0] exp_note,
                           input logic exp_write, input logic exp_busy, input logic [3:0] exp_step,
                           input logic chk_sample, input logic [23:0] exp_sample);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      checkOutput({tag, " note_id"}, note_id, exp_note);
      checkOutput({tag, " write"}, codec_bus.write, exp_write);
      checkOutput({tag, " busy"}, busy, exp_busy);
      checkOutput({tag, " step_idx"}, step_idx, exp_step);
      checkOutput({tag, " done"}, done, 1'b0);
      if (chk_sample) begin
        checkOutput({tag, " sample_left"}, codec_bus.sample_left, exp_sample);
        checkOutput({tag, " sample_right"}, codec_bus.sample_right, exp_sample);
      end
    end
  endtask

  initial begin
    // Reset held low with start high: everything stays at zero
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    checkSpan("reset", 3, 3'd0, 1'b0, 1'b0, 4'd0, 1'b1, 24'd0);

    // Release reset with start still high: LOAD after the first live edge
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    checkSpan("load0", 1, 3'd0, 1'b0, 1'b1, 4'd0, 1'b1, 24'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // C for two beats; phase flips after 11 clocks, sample follows one clock later
    for (int k = 0; k < 2 * BEAT; k++) begin
      @(negedge clock);
      checkOutput("noteC note_id", note_id, 3'd1);
      checkOutput("noteC write", codec_bus.write, 1'b1);
      checkOutput("noteC busy", busy, 1'b1);
      checkOutput("noteC sample_left", codec_bus.sample_left, (k <= 11) ? NEG : POS);
      checkOutput("noteC sample_right", codec_bus.sample_right, (k <= 11) ? NEG : POS);
    end

    // Rest of the tune with full handshake
    checkSpan("gap0 first", 1, 3'd0, 1'b1, 1'b1, 4'd0, 1'b1, POS);
    checkSpan("gap0", BEAT - 1, 3'd0, 1'b1, 1'b1, 4'd0, 1'b1, 24'd0);
    checkSpan("next0", 1, 3'd0, 1'b0, 1'b1, 4'd0, 1'b1, 24'd0);
    checkSpan("load1", 1, 3'd0, 1'b0, 1'b1, 4'd1, 1'b1, 24'd0);
    checkSpan("rest", BEAT, 3'd0, 1'b1, 1'b1, 4'd1, 1'b1, 24'd0);
    checkSpan("gap1", BEAT, 3'd0, 1'b1, 1'b1, 4'd1, 1'b1, 24'd0);
    checkSpan("next1", 1, 3'd0, 1'b0, 1'b1, 4'd1, 1'b1, 24'd0);
    checkSpan("load2", 1, 3'd0, 1'b0, 1'b1, 4'd2, 1'b1, 24'd0);
    checkSpan("noteE start", 1, 3'd3, 1'b1, 1'b1, 4'd2, 1'b1, NEG);
    checkSpan("noteE", BEAT - 1, 3'd3, 1'b1, 1'b1, 4'd2, 1'b0, 24'd0);
    checkSpan("gap2", BEAT, 3'd0, 1'b1, 1'b1, 4'd2, 1'b0, 24'd0);
    checkSpan("next2", 1, 3'd0, 1'b0, 1'b1, 4'd2, 1'b1, 24'd0);
    checkSpan("load3", 1, 3'd0, 1'b0, 1'b1, 4'd3, 1'b1, 24'd0);
    @(negedge clock);
    checkOutput("end done", done, 1'b1);
    checkOutput("end busy", busy, 1'b1);
    checkOutput("end write", codec_bus.write, 1'b0);
    checkOutput("end step_idx", step_idx, 4'd3);
    checkSpan("idle after song", 3, 3'd0, 1'b0, 1'b0, 4'd0, 1'b1, 24'd0);

    // stop on the third cycle of C, held with start high: stays idle, no done
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    checkSpan("stop load", 1, 3'd0, 1'b0, 1'b1, 4'd0, 1'b1, 24'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkSpan("stop noteC", 3, 3'd1, 1'b1, 1'b1, 4'd0, 1'b1, NEG);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    checkSpan("stopped", 3, 3'd0, 1'b0, 1'b0, 4'd0, 1'b1, 24'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkSpan("idle after stop", 1, 3'd0, 1'b0, 1'b0, 4'd0, 1'b1, 24'd0);

    // write_ready low for 10 edges inside C: sample frozen, timing unaffected
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    checkSpan("stall load", 1, 3'd0, 1'b0, 1'b1, 4'd0, 1'b1, 24'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkSpan("stall pre", 3, 3'd1, 1'b1, 1'b1, 4'd0, 1'b1, NEG);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkSpan("stall held", 10, 3'd1, 1'b1, 1'b1, 4'd0, 1'b1, NEG);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkSpan("stall resume", 1, 3'd1, 1'b1, 1'b1, 4'd0, 1'b1, POS);
    checkSpan("stall tail", 2, 3'd1, 1'b1, 1'b1, 4'd0, 1'b0, 24'd0);
    checkSpan("stall gap", 1, 3'd0, 1'b1, 1'b1, 4'd0, 1'b1, POS);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    checkSpan("stall stop", 1, 3'd0, 1'b0, 1'b0, 4'd0, 1'b1, 24'd0);

    // Reset in the middle of a note aborts silently
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    checkSpan("rst load", 1, 3'd0, 1'b0, 1'b1, 4'd0, 1'b1, 24'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkSpan("rst noteC", 2, 3'd1, 1'b1, 1'b1, 4'd0, 1'b1, NEG);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkSpan("rst mid note", 2, 3'd0, 1'b0, 1'b0, 4'd0, 1'b1, 24'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkSpan("rst released", 1, 3'd0, 1'b0, 1'b0, 4'd0, 1'b1, 24'd0);

    // Looping with start held high throughout: done after 63 cycles, then LOAD directly
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    checkSpan("loop load", 1, 3'd0, 1'b0, 1'b1, 4'd0, 1'b1, 24'd0);
    cycles = 0;
    while ((done !== 1'b1) && (cycles < 200)) begin
      @(negedge clock);
      cycles++;
    end
    checkOutput("loop done latency", cycles, 32'd63);
    checkSpan("loop reload", 1, 3'd0, 1'b0, 1'b1, 4'd0, 1'b1, 24'd0);
    checkSpan("loop replay", 1, 3'd1, 1'b1, 1'b1, 4'd0, 1'b1, NEG);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    checkSpan("loop stop", 2, 3'd0, 1'b0, 1'b0, 4'd0, 1'b1, 24'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
    $finish;
  end

endmodule
